// File: rtl/sobel_pkg.sv
// sobel_pkg: shared sequencer states and default image geometry for the Sobel front end.
package sobel_pkg;
    localparam int DEF_IMG_WIDTH  = 640;
    localparam int DEF_IMG_HEIGHT = 480;
    localparam int DEF_CNT_W      = 10;
    typedef enum logic [1:0] {S_IDLE, S_FILL, S_RUN, S_DONE} state_t;
endpackage

// File: rtl/sobel_window_ctrl_if.sv
// sobel_window_ctrl_if: pixel-source handshake and line-buffer/window controls of the sequencer.
interface sobel_window_ctrl_if #(parameter int CNT_W = 10) ();
    logic             sof_i;
    logic             pix_valid_i;
    logic             lb_we_o;
    logic             lb_clr_o;
    logic             win_valid_o;
    logic [CNT_W-1:0] win_row_o;
    logic [CNT_W-1:0] win_col_o;
    logic             busy_o;
    logic             frame_done_o;
    logic             frame_abort_o;
    modport master (output sof_i, pix_valid_i,
                    input  lb_we_o, lb_clr_o, win_valid_o, win_row_o, win_col_o,
                           busy_o, frame_done_o, frame_abort_o);
    modport slave  (input  sof_i, pix_valid_i,
                    output lb_we_o, lb_clr_o, win_valid_o, win_row_o, win_col_o,
                           busy_o, frame_done_o, frame_abort_o);
endinterface

// File: rtl/sobel_pos_counter.sv
// sobel_pos_counter: row/column position of the next accepted pixel, wrapping at the row end and at frame end.
module sobel_pos_counter
    import sobel_pkg::*;
#(
    parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
    parameter int IMG_HEIGHT = DEF_IMG_HEIGHT,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_adv,
    output logic [CNT_W-1:0] o_row,
    output logic [CNT_W-1:0] o_col,
    output logic             o_last
);
    logic w_row_end;
    assign w_row_end = o_col == CNT_W'(IMG_WIDTH - 1);
    assign o_last    = w_row_end && o_row == CNT_W'(IMG_HEIGHT - 1);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_row <= '0;
            o_col <= '0;
        end else if (i_clr || (i_adv && o_last)) begin
            o_row <= '0;
            o_col <= '0;
        end else if (i_adv) begin
            o_col <= w_row_end ? '0 : o_col + CNT_W'(1);
            o_row <= w_row_end ? o_row + CNT_W'(1) : o_row;
        end
    end
endmodule

// File: rtl/sobel_window_ctrl.sv
// sobel_window_ctrl: frame sequencer driving line-buffer write/clear and flagging interior 3x3 windows.
module sobel_window_ctrl
    import sobel_pkg::*;
#(
    parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
    parameter int IMG_HEIGHT = DEF_IMG_HEIGHT,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    sobel_window_ctrl_if.slave bus
);
    state_t           r_state, w_state_nxt;
    logic             w_abort, w_accept, w_last, w_interior;
    logic [CNT_W-1:0] w_row, w_col;
    logic             r_win_valid, r_frame_abort;
    logic [CNT_W-1:0] r_win_row, r_win_col;

    sobel_pos_counter #(.IMG_WIDTH(IMG_WIDTH), .IMG_HEIGHT(IMG_HEIGHT), .CNT_W(CNT_W)) u_pos (
        .clk(clk), .rst_n(rst_n), .i_clr(w_abort), .i_adv(w_accept),
        .o_row(w_row), .o_col(w_col), .o_last(w_last)
    );

    assign w_abort    = bus.sof_i && (r_state == S_FILL || r_state == S_RUN);
    assign w_accept   = bus.pix_valid_i && !w_abort &&
                        ((r_state == S_IDLE && bus.sof_i) || r_state == S_FILL || r_state == S_RUN);
    assign w_interior = w_row >= CNT_W'(2) && w_col >= CNT_W'(2);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  w_state_nxt = w_accept ? S_FILL : S_IDLE;
            S_FILL:  w_state_nxt = w_abort ? S_IDLE
                                 : (w_accept && w_row == CNT_W'(2) && w_col == CNT_W'(2)) ? S_RUN : S_FILL;
            S_RUN:   w_state_nxt = w_abort ? S_IDLE : (w_accept && w_last) ? S_DONE : S_RUN;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_win_valid   <= 1'b0;
            r_win_row     <= '0;
            r_win_col     <= '0;
            r_frame_abort <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_win_valid   <= w_accept && w_interior;
            r_frame_abort <= w_abort;
            if (w_accept && w_interior) begin
                r_win_row <= w_row - CNT_W'(1);
                r_win_col <= w_col - CNT_W'(1);
            end
        end
    end

    // Clear follows reset asynchronously so the line buffers are held clear while rst_n is low.
    assign bus.lb_clr_o      = !rst_n || w_abort;
    assign bus.lb_we_o       = w_accept;
    assign bus.win_valid_o   = r_win_valid;
    assign bus.win_row_o     = r_win_row;
    assign bus.win_col_o     = r_win_col;
    assign bus.busy_o        = r_state == S_FILL || r_state == S_RUN;
    assign bus.frame_done_o  = r_state == S_DONE;
    assign bus.frame_abort_o = r_frame_abort;
endmodule

// File: tb/tb_sobel_window_ctrl.sv
// tb_sobel_window_ctrl: table vectors, directed frame sequences and random stimulus against a pixel-index model.
module tb_sobel_window_ctrl;
    localparam int W = 5;
    localparam int H = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sobel_window_ctrl_if #(.CNT_W(10)) bus ();
    sobel_window_ctrl #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .CNT_W(10)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    int checks = 0;
    int failures = 0;

    // Model: a frame is just an index k into W*H accepted pixels.
    bit in_frame, done_pend;
    int k;
    bit e_wv, e_ab;
    int e_row, e_col;
    int dut_wins, dut_dones, first_row, first_col;

    typedef struct {
        logic sof, pv, we, clr, busy, ab;
    } vec_t;
    vec_t tbl [9];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        in_frame = 0; done_pend = 0; k = 0;
        e_wv = 0; e_ab = 0; e_row = 0; e_col = 0;
    endtask

    task automatic step(input logic s, input logic v);
        bit m_abort, m_acc;
        int r, c;
        @(negedge clk);
        bus.sof_i = s;
        bus.pix_valid_i = v;
        #1;
        m_abort = !done_pend && in_frame && s;
        m_acc   = !done_pend && !m_abort && v && (in_frame || s);
        chk("lb_we", bus.lb_we_o, m_acc);
        chk("lb_clr", bus.lb_clr_o, m_abort);
        chk("busy", bus.busy_o, in_frame);
        chk("frame_done", bus.frame_done_o, done_pend);
        chk("win_valid", bus.win_valid_o, e_wv);
        chk("win_row", bus.win_row_o, e_row);
        chk("win_col", bus.win_col_o, e_col);
        chk("frame_abort", bus.frame_abort_o, e_ab);
        if (bus.win_valid_o) begin
            if (dut_wins == 0) begin
                first_row = bus.win_row_o;
                first_col = bus.win_col_o;
            end
            dut_wins++;
        end
        if (bus.frame_done_o) dut_dones++;
        e_wv = 0;
        e_ab = m_abort;
        if (done_pend) done_pend = 0;
        else if (m_abort) begin
            in_frame = 0;
            k = 0;
        end else if (m_acc) begin
            r = k / W;
            c = k % W;
            if (r >= 2 && c >= 2) begin
                e_wv = 1; e_row = r - 1; e_col = c - 1;
            end
            k++;
            in_frame = 1;
            if (k == W * H) begin
                k = 0; in_frame = 0; done_pend = 1;
            end
        end
    endtask

    task automatic frame(input bit gaps);
        step(1, 1);
        for (int i = 1; i < W * H; i++) begin
            if (gaps) step(0, 0);
            step(0, 1);
        end
    endtask

    task automatic clear_counts();
        dut_wins = 0; dut_dones = 0; first_row = -1; first_col = -1;
    endtask

    initial begin
        tbl[0] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[2] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[3] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[4] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        bus.sof_i = 0;
        bus.pix_valid_i = 0;
        model_reset();
        clear_counts();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_clr", bus.lb_clr_o, 1);
        chk("rst_busy", bus.busy_o, 0);
        chk("rst_win_valid", bus.win_valid_o, 0);
        chk("rst_win_row", bus.win_row_o, 0);
        @(negedge clk);
        rst_n = 1;

        for (int i = 0; i < 9; i++) begin
            step(tbl[i].sof, tbl[i].pv);
            chk("tbl_we", bus.lb_we_o, tbl[i].we);
            chk("tbl_clr", bus.lb_clr_o, tbl[i].clr);
            chk("tbl_busy", bus.busy_o, tbl[i].busy);
            chk("tbl_abort", bus.frame_abort_o, tbl[i].ab);
        end

        clear_counts();
        frame(0);
        repeat (3) step(0, 0);
        chk("full_wins", dut_wins, 6);
        chk("full_dones", dut_dones, 1);
        chk("full_first_row", first_row, 1);
        chk("full_first_col", first_col, 1);
        chk("full_last_row", bus.win_row_o, 2);
        chk("full_last_col", bus.win_col_o, 3);

        clear_counts();
        frame(1);
        repeat (3) step(0, 0);
        chk("gap_wins", dut_wins, 6);
        chk("gap_dones", dut_dones, 1);

        clear_counts();
        repeat (3) step(0, 1);
        frame(0);
        repeat (2) step(0, 0);
        chk("ignore_wins", dut_wins, 6);

        clear_counts();
        step(1, 1);
        for (int i = 1; i < 8; i++) step(0, 1);
        step(1, 1);
        chk("abort_clr", bus.lb_clr_o, 1);
        chk("abort_we", bus.lb_we_o, 0);
        repeat (2) step(0, 1);
        chk("abort_no_win", dut_wins, 0);
        frame(0);
        repeat (2) step(0, 0);
        chk("after_abort_wins", dut_wins, 6);

        clear_counts();
        frame(0);
        step(1, 1);
        frame(0);
        repeat (2) step(0, 0);
        chk("b2b_wins", dut_wins, 12);
        chk("b2b_dones", dut_dones, 2);

        clear_counts();
        step(1, 1);
        for (int i = 0; i < 9; i++) step(0, 1);
        @(negedge clk);
        #3;
        rst_n = 0;
        #1;
        chk("async_clr", bus.lb_clr_o, 1);
        chk("async_busy", bus.busy_o, 0);
        chk("async_we", bus.lb_we_o, 0);
        chk("async_win_col", bus.win_col_o, 0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1;

        for (int i = 0; i < 600; i++)
            step(($urandom_range(0, 15) == 0) ? 1'b1 : 1'b0, ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
